// File: rtl/uart_output_control_if.sv
// Byte stream from the output FIFO to the UART transmitter.
// Master drives data/valid, slave answers with ready.
interface uart_output_control_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_output_control.sv
// Output side of the CPU UART path: "out" bytes are queued in a FIFO
// and drained to the transmitter; the PC is frozen only when it is full.
module uart_output_control #(
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       distinct,
    input  logic                       RegtoUART,
    input  logic [31:0]                write_data,
    uart_output_control_if.master      tx,
    output logic                       pc_enable,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_count
);
    localparam int L     = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 2 ** L;

    localparam logic [L-1:0] PTR_ONE   = 1;
    localparam logic [L:0]   CNT_ONE   = 1;
    localparam logic [L:0]   CNT_DEPTH = DEPTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         pc_enable_q, pc_enable_d;
    logic [L:0]   count_q, count_d;
    logic [L-1:0] wr_ptr_q, wr_ptr_d;
    logic [L-1:0] rd_ptr_q, rd_ptr_d;
    logic         tx_valid_q, tx_valid_d;
    logic [7:0]   tx_data_q, tx_data_d;
    logic [7:0]   mem_q [DEPTH];

    logic full;
    logic empty;
    logic enq;
    logic deq;
    logic hs;

    assign full  = (count_q == CNT_DEPTH);
    assign empty = (count_q == '0);

    // Request FSM: one enqueue per out instruction, stall while full
    always_comb begin
        state_d     = state_q;
        pc_enable_d = pc_enable_q;
        enq         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (RegtoUART) begin
                    if (!full) begin
                        enq     = 1'b1;
                        state_d = DONE;
                    end else begin
                        pc_enable_d = 1'b0;
                        state_d     = STALL;
                    end
                end
            end
            STALL: begin
                if (!full) begin
                    enq         = 1'b1;
                    pc_enable_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (distinct) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                pc_enable_d = 1'b1;
            end
        endcase
    end

    // Output register refill and FIFO pointer/count bookkeeping
    always_comb begin
        hs         = tx_valid_q & tx.tx_ready;
        deq        = (!tx_valid_q || hs) && !empty;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (deq) begin
            tx_data_d  = mem_q[rd_ptr_q];
            tx_valid_d = 1'b1;
        end else if (hs) begin
            tx_valid_d = 1'b0;
        end

        wr_ptr_d = enq ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        count_d = count_q;
        if (enq && !deq) begin
            count_d = count_q + CNT_ONE;
        end else if (deq && !enq) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_enable_q <= 1'b1;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_enable_q <= pc_enable_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
        end
    end

    // FIFO storage; contents need no reset
    always_ff @(posedge CLK) begin
        if (enq && !reset) begin
            mem_q[wr_ptr_q] <= write_data[7:0];
        end
    end

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign pc_enable   = pc_enable_q;
    assign fifo_count  = count_q;
endmodule

// File: tb/tb_uart_output_control.sv
// Directed bench for uart_output_control: a scoreboard queue holds the
// bytes expected on the transmitter side, in order.
module tb_uart_output_control;
    logic        CLK = 1'b0;
    logic        reset;
    logic        distinct;
    logic        RegtoUART;
    logic [31:0] write_data;
    logic        pc_enable;
    logic [3:0]  fifo_count;

    uart_output_control_if tx_if ();

    uart_output_control #(.FIFO_DEPTH_LOG2(3)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .distinct   (distinct),
        .RegtoUART  (RegtoUART),
        .write_data (write_data),
        .tx         (tx_if.master),
        .pc_enable  (pc_enable),
        .fifo_count (fifo_count)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rx     = 0;
    logic [7:0] exp_q [$];
    bit mon_en   = 1'b0;
    bit wrap_mode = 1'b0;

    // Single point of comparison
    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Transmit-side monitor against the scoreboard
    always @(negedge CLK) begin
        if (mon_en) begin
            if (tx_if.tx_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", {31'd0, tx_if.tx_valid}, 32'd0);
                end else begin
                    check("tx_data", {24'd0, tx_if.tx_data},
                          {24'd0, exp_q[0]});
                    if (tx_if.tx_ready) begin
                        void'(exp_q.pop_front());
                        n_rx++;
                    end
                end
            end
            if (wrap_mode) begin
                check("wrap_pc_enable", {31'd0, pc_enable}, 32'd1);
                check("wrap_count_le1", {31'd0, fifo_count <= 4'd1}, 32'd1);
            end
        end
    end

    // One out instruction: distinct pulse, RegtoUART held 3 cycles
    task automatic issue(input logic [7:0] b);
        distinct   = 1'b1;
        RegtoUART  = 1'b1;
        write_data = {24'hC0FFEE, b};
        exp_q.push_back(b);
        tick();
        distinct = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            tick();
        end
        check("drain", exp_q.size(), 32'd0);
    endtask

    int rx_base;

    initial begin
        reset      = 1'b1;
        distinct   = 1'b0;
        RegtoUART  = 1'b0;
        write_data = '0;
        tx_if.tx_ready = 1'b0;
        tick();
        tick();
        check("rst_tx_valid", {31'd0, tx_if.tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_if.tx_data}, 32'd0);
        check("rst_pc_enable", {31'd0, pc_enable}, 32'd1);
        check("rst_fifo_count", {28'd0, fifo_count}, 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();

        // Single out, two-edge latency, one-cycle valid
        tx_if.tx_ready = 1'b1;
        distinct   = 1'b1;
        RegtoUART  = 1'b1;
        write_data = 32'h1234_5641;
        exp_q.push_back(8'h41);
        tick();
        distinct = 1'b0;
        check("single_count1", {28'd0, fifo_count}, 32'd1);
        check("single_not_yet", {31'd0, tx_if.tx_valid}, 32'd0);
        tick();
        check("single_valid", {31'd0, tx_if.tx_valid}, 32'd1);
        check("single_data", {24'd0, tx_if.tx_data}, 32'h41);
        check("single_pc", {31'd0, pc_enable}, 32'd1);
        tick();
        check("single_one_cycle", {31'd0, tx_if.tx_valid}, 32'd0);
        RegtoUART = 1'b0;
        tick();

        // RegtoUART held 10 cycles with a single distinct pulse
        rx_base    = n_rx;
        distinct   = 1'b1;
        RegtoUART  = 1'b1;
        write_data = 32'hAAAA_AA5A;
        exp_q.push_back(8'h5A);
        tick();
        distinct = 1'b0;
        repeat (9) tick();
        RegtoUART = 1'b0;
        repeat (4) tick();
        check("hold_one_byte", n_rx - rx_base, 32'd1);

        // Fill to capacity and stall
        tx_if.tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) issue(8'(i));
        check("fill_count8", {28'd0, fifo_count}, 32'd8);
        check("fill_out_valid", {31'd0, tx_if.tx_valid}, 32'd1);
        check("fill_out_data", {24'd0, tx_if.tx_data}, 32'h00);
        check("fill_pc_before", {31'd0, pc_enable}, 32'd1);
        distinct   = 1'b1;
        write_data = 32'hC0FFEE09;
        exp_q.push_back(8'h09);
        tick();
        distinct = 1'b0;
        tick();
        check("stall_pc0", {31'd0, pc_enable}, 32'd0);
        repeat (3) tick();
        check("stall_pc0_held", {31'd0, pc_enable}, 32'd0);
        tx_if.tx_ready = 1'b1;
        tick();
        check("stall_pc0_after_hs", {31'd0, pc_enable}, 32'd0);
        tick();
        check("stall_pc1", {31'd0, pc_enable}, 32'd1);
        RegtoUART = 1'b0;
        wait_drain();

        // Backpressure with ready pattern 1,0,0,1,...
        tx_if.tx_ready = 1'b0;
        rx_base = n_rx;
        issue(8'hA1);
        issue(8'hA2);
        issue(8'hA3);
        RegtoUART = 1'b0;
        begin
            logic [7:0] pat;
            pat = 8'b1110_1001;
            for (int i = 0; i < 8; i++) begin
                tx_if.tx_ready = pat[i];
                tick();
            end
        end
        tx_if.tx_ready = 1'b1;
        wait_drain();
        check("bp_three_bytes", n_rx - rx_base, 32'd3);

        // Pointer wrap with free-running transmitter
        rx_base   = n_rx;
        wrap_mode = 1'b1;
        for (int i = 0; i < 20; i++) issue(8'h50 + 8'(i));
        RegtoUART = 1'b0;
        wait_drain();
        wrap_mode = 1'b0;
        check("wrap_20_bytes", n_rx - rx_base, 32'd20);

        // Reset while stalled
        tx_if.tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) issue(8'hE0 + 8'(i));
        distinct   = 1'b1;
        write_data = 32'hC0FFEEEF;
        tick();
        distinct = 1'b0;
        tick();
        check("mid_count8", {28'd0, fifo_count}, 32'd8);
        check("mid_pc0", {31'd0, pc_enable}, 32'd0);
        mon_en    = 1'b0;
        reset     = 1'b1;
        RegtoUART = 1'b0;
        tick();
        reset = 1'b0;
        exp_q.delete();
        check("mid_rst_pc", {31'd0, pc_enable}, 32'd1);
        check("mid_rst_valid", {31'd0, tx_if.tx_valid}, 32'd0);
        check("mid_rst_count", {28'd0, fifo_count}, 32'd0);
        mon_en = 1'b1;
        rx_base = n_rx;
        tx_if.tx_ready = 1'b1;
        repeat (10) tick();
        check("mid_no_stale", n_rx - rx_base, 32'd0);
        issue(8'h77);
        RegtoUART = 1'b0;
        wait_drain();
        check("mid_after_rst", n_rx - rx_base, 32'd1);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
